// File: rtl/window_bank_manager_pkg.sv
// Shared types and defaults for the window/variance cache bank manager.
// Bank 0/1 correspond to the legacy A/B double buffer when NUM_BANKS is 2.
package window_bank_manager_pkg;

    localparam int DEFAULT_NUM_BANKS = 2;
    localparam int DEFAULT_ADDR_W    = 10;
    localparam int DEFAULT_DATA_W    = 32;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        BUSY    = 2'd3
    } bank_state_t;

    typedef struct packed {
        logic fill_valid;
        logic fill_done;
        logic wr_we;
    } struct_bank_fill;

    typedef struct packed {
        logic offer;
        logic ready;
        logic done;
    } struct_bank_dispatch;

endpackage

// File: rtl/window_bank_manager_if.sv
// Loader, consumer and bank-side signals of the bank manager.
// The manager uses the slave modport; loader/consumers drive the master side.
interface window_bank_manager_if
    import window_bank_manager_pkg::*;
#(
    parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                 fill_valid;
    logic                 fill_ready;
    logic [BANK_W-1:0]    fill_bank;
    logic                 fill_done;
    logic                 wr_we;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_BANKS-1:0] bank_we;
    logic [ADDR_W-1:0]    bank_waddr;
    logic [DATA_W-1:0]    bank_wdata;
    logic                 eval_valid;
    logic                 eval_ready;
    logic [BANK_W-1:0]    eval_bank;
    logic                 eval_done;
    logic [BANK_W-1:0]    eval_done_bank;
    logic                 var_valid;
    logic                 var_ready;
    logic [BANK_W-1:0]    var_bank;
    logic                 var_done;
    logic [BANK_W-1:0]    var_done_bank;
    logic [BANK_W:0]      free_count;
    logic                 err;

    modport master (
        output fill_valid, fill_done, wr_we, wr_addr, wr_data,
        output eval_ready, eval_done, eval_done_bank,
        output var_ready, var_done, var_done_bank,
        input  fill_ready, fill_bank, bank_we, bank_waddr, bank_wdata,
        input  eval_valid, eval_bank, var_valid, var_bank, free_count, err
    );

    modport slave (
        input  fill_valid, fill_done, wr_we, wr_addr, wr_data,
        input  eval_ready, eval_done, eval_done_bank,
        input  var_ready, var_done, var_done_bank,
        output fill_ready, fill_bank, bank_we, bank_waddr, bank_wdata,
        output eval_valid, eval_bank, var_valid, var_bank, free_count, err
    );

endinterface

// File: rtl/window_bank_manager_dispatch_port.sv
// One consumer's view of bank dispatch: tracks whether the current offer was
// accepted and which BUSY banks this consumer has reported done.
module window_bank_manager_dispatch_port
    import window_bank_manager_pkg::*;
#(
    parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  struct_bank_dispatch  req,
    input  logic [BANK_W-1:0]    done_bank,
    input  logic                 both_accepted,
    input  logic [NUM_BANKS-1:0] busy,
    input  logic [NUM_BANKS-1:0] release_vec,
    output logic                 valid,
    output logic                 accepted,
    output logic [NUM_BANKS-1:0] done_vec,
    output logic                 done_err
);

    logic                 accepted_q, accepted_d;
    logic [NUM_BANKS-1:0] done_q, done_d, done_set;

    assign valid    = req.offer && !accepted_q;
    assign accepted = accepted_q || (valid && req.ready);

    // The flag stays set until the other consumer has also taken the offer.
    always_comb begin
        accepted_d = accepted && !both_accepted;
    end

    // A done only counts for a BUSY bank not already reported by this consumer.
    always_comb begin
        done_set = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (req.done && (done_bank == BANK_W'(b)) && busy[b] && !done_q[b]) begin
                done_set[b] = 1'b1;
            end
        end
        done_err = req.done && (done_set == '0);
        done_vec = done_q | done_set;
    end

    always_comb begin
        done_d = done_vec & ~release_vec;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            accepted_q <= 1'b0;
            done_q     <= '0;
        end else begin
            accepted_q <= accepted_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: rtl/window_bank_manager.sv
// N-bank ownership manager: loader fills a FREE bank, both consumers receive it
// in fill order, and the bank returns to FREE once both have reported done.
module window_bank_manager
    import window_bank_manager_pkg::*;
#(
    parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input logic                  clk,
    input logic                  resetn,
    window_bank_manager_if.slave bus
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    bank_state_t          state_q [NUM_BANKS];
    bank_state_t          state_d [NUM_BANKS];
    logic [BANK_W-1:0]    fill_ptr_q, fill_ptr_d;
    logic [BANK_W-1:0]    disp_ptr_q, disp_ptr_d;
    logic                 err_q, err_d;
    logic [NUM_BANKS-1:0] bank_we_q, bank_we_d;
    logic [ADDR_W-1:0]    bank_waddr_q, bank_waddr_d;
    logic [DATA_W-1:0]    bank_wdata_q, bank_wdata_d;

    struct_bank_fill      fill_in;
    struct_bank_dispatch  eval_req, var_req;
    logic                 filling_any, fill_ptr_free, disp_ready, fill_ready, fill_grant;
    logic [NUM_BANKS-1:0] busy, release_vec, eval_done_vec, var_done_vec;
    logic                 eval_valid, var_valid, eval_accepted, var_accepted, both_accepted;
    logic                 eval_done_err, var_done_err;
    logic [BANK_W:0]      free_count;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] ptr);
        return (ptr == LAST_BANK) ? '0 : ptr + 1'b1;
    endfunction

    assign fill_in = '{fill_valid: bus.fill_valid, fill_done: bus.fill_done, wr_we: bus.wr_we};

    always_comb begin
        filling_any   = 1'b0;
        fill_ptr_free = 1'b0;
        disp_ready    = 1'b0;
        busy          = '0;
        free_count    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q[b] == FILLING) filling_any = 1'b1;
            if (state_q[b] == BUSY) busy[b] = 1'b1;
            if (state_q[b] == FREE) free_count = free_count + (BANK_W+1)'(1);
            if ((BANK_W'(b) == fill_ptr_q) && (state_q[b] == FREE)) fill_ptr_free = 1'b1;
            if ((BANK_W'(b) == disp_ptr_q) && (state_q[b] == READY)) disp_ready = 1'b1;
        end
    end

    assign fill_ready    = fill_ptr_free && !filling_any;
    assign fill_grant    = fill_in.fill_valid && fill_ready;
    assign eval_req      = '{offer: disp_ready, ready: bus.eval_ready, done: bus.eval_done};
    assign var_req       = '{offer: disp_ready, ready: bus.var_ready, done: bus.var_done};
    assign both_accepted = disp_ready && eval_accepted && var_accepted;
    assign release_vec   = busy & eval_done_vec & var_done_vec;

    window_bank_manager_dispatch_port #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_eval_port (
        .clk(clk), .resetn(resetn), .req(eval_req), .done_bank(bus.eval_done_bank),
        .both_accepted(both_accepted), .busy(busy), .release_vec(release_vec),
        .valid(eval_valid), .accepted(eval_accepted), .done_vec(eval_done_vec),
        .done_err(eval_done_err)
    );

    window_bank_manager_dispatch_port #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_var_port (
        .clk(clk), .resetn(resetn), .req(var_req), .done_bank(bus.var_done_bank),
        .both_accepted(both_accepted), .busy(busy), .release_vec(release_vec),
        .valid(var_valid), .accepted(var_accepted), .done_vec(var_done_vec),
        .done_err(var_done_err)
    );

    // The FILLING bank is always fill_ptr: the pointer only moves on fill_done.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) state_d[b] = state_q[b];
        fill_ptr_d   = fill_ptr_q;
        disp_ptr_d   = disp_ptr_q;
        err_d        = err_q;
        bank_we_d    = '0;
        bank_waddr_d = bank_waddr_q;
        bank_wdata_d = bank_wdata_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (fill_grant && (BANK_W'(b) == fill_ptr_q)) state_d[b] = FILLING;
            if (fill_in.fill_done && filling_any && (BANK_W'(b) == fill_ptr_q)) state_d[b] = READY;
            if (both_accepted && (BANK_W'(b) == disp_ptr_q)) state_d[b] = BUSY;
            if (release_vec[b]) state_d[b] = FREE;
            if (fill_in.wr_we && filling_any && (BANK_W'(b) == fill_ptr_q)) bank_we_d[b] = 1'b1;
        end
        if (fill_in.wr_we && filling_any) begin
            bank_waddr_d = bus.wr_addr;
            bank_wdata_d = bus.wr_data;
        end
        if (fill_in.fill_done && filling_any) fill_ptr_d = next_bank(fill_ptr_q);
        if (both_accepted) disp_ptr_d = next_bank(disp_ptr_q);
        if (((fill_in.wr_we || fill_in.fill_done) && !filling_any) || eval_done_err || var_done_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= FREE;
            fill_ptr_q   <= '0;
            disp_ptr_q   <= '0;
            err_q        <= 1'b0;
            bank_we_q    <= '0;
            bank_waddr_q <= '0;
            bank_wdata_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= state_d[b];
            fill_ptr_q   <= fill_ptr_d;
            disp_ptr_q   <= disp_ptr_d;
            err_q        <= err_d;
            bank_we_q    <= bank_we_d;
            bank_waddr_q <= bank_waddr_d;
            bank_wdata_q <= bank_wdata_d;
        end
    end

    assign bus.fill_ready = fill_ready;
    assign bus.fill_bank  = fill_ptr_q;
    assign bus.bank_we    = bank_we_q;
    assign bus.bank_waddr = bank_waddr_q;
    assign bus.bank_wdata = bank_wdata_q;
    assign bus.eval_valid = eval_valid;
    assign bus.eval_bank  = disp_ptr_q;
    assign bus.var_valid  = var_valid;
    assign bus.var_bank   = disp_ptr_q;
    assign bus.free_count = free_count;
    assign bus.err        = err_q;

endmodule
